// File: rtl/ninjin_ddr_resp.sv
`default_nettype none
// ============================================================================
// Module      : ninjin_ddr_resp
// Description : AXI4 memory-side responder for the ninjin m_axi_image master.
//               Backs 2**MEMSIZE words of DATA_WIDTH bits with a synchronous,
//               read-first RAM. Independent write (AW/W/B) and read (AR/R)
//               state machines; every burst is handled as INCR of full-width
//               beats, with the word index wrapping modulo the memory depth.
// Ports       : clk, rst (sync, active-high)
//               AW : awid, awaddr, awlen, awsize, awburst, awvalid / awready
//               W  : wdata, wstrb, wlast, wvalid / wready
//               B  : bid, bresp, bvalid / bready
//               AR : arid, araddr, arlen, arsize, arburst, arvalid / arready
//               R  : rid, rdata, rresp, rlast, rvalid / rready
// Revision    : 1.0 - initial release
// ============================================================================
module ninjin_ddr_resp #(
    parameter int ID_WIDTH   = 1,
    parameter int MEMSIZE    = 10,              // log2 of word depth
    parameter int LSB        = 2,               // byte-offset bits
    parameter int ADDR_WIDTH = MEMSIZE + LSB,   // byte-address width
    parameter int DATA_WIDTH = 32               // beat width
) (
    input  logic                    clk,
    input  logic                    rst,
    // write address
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    // write data
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    // write response
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    // read address
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    // read data
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int          c_NBYTES = DATA_WIDTH / 8;
    localparam logic [1:0]  c_OKAY   = 2'b00;
    localparam logic [1:0]  c_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rstate_t;

    // Size/burst type are deliberately ignored; the upper address bits too.
    logic w_unused;
    assign w_unused = ^{awsize, awburst, arsize, arburst, awaddr, araddr};

    logic [DATA_WIDTH-1:0] r_mem [0:(1 << MEMSIZE)-1];

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wstate_t               r_wstate;
    logic [ID_WIDTH-1:0]   r_bid;
    logic [1:0]            r_bresp;
    logic [MEMSIZE-1:0]    r_widx;
    logic [7:0]            r_wlen;
    logic [7:0]            r_wcnt;
    logic                  r_wlast_ok;   // wlast matched beat position so far

    logic w_we;
    logic w_wfinal;
    logic w_wlast_good;

    assign w_we         = (r_wstate == W_DATA) && wvalid;
    assign w_wfinal     = (r_wcnt == r_wlen);
    assign w_wlast_good = (wlast == w_wfinal);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate   <= W_IDLE;
            r_bid      <= '0;
            r_bresp    <= c_OKAY;
            r_widx     <= '0;
            r_wlen     <= '0;
            r_wcnt     <= '0;
            r_wlast_ok <= 1'b1;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (awvalid) begin
                        r_bid      <= awid;
                        r_widx     <= awaddr[LSB +: MEMSIZE];
                        r_wlen     <= awlen;
                        r_wcnt     <= '0;
                        r_wlast_ok <= 1'b1;
                        r_wstate   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        r_widx     <= r_widx + 1'b1;
                        r_wcnt     <= r_wcnt + 8'd1;
                        r_wlast_ok <= r_wlast_ok & w_wlast_good;
                        // Burst length comes from awlen alone; wlast only
                        // affects the response code.
                        if (w_wfinal) begin
                            r_bresp  <= (r_wlast_ok && w_wlast_good) ? c_OKAY : c_SLVERR;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    assign awready = (r_wstate == W_IDLE);
    assign wready  = (r_wstate == W_DATA);
    assign bvalid  = (r_wstate == W_RESP);
    assign bid     = r_bid;
    assign bresp   = r_bresp;

    // Byte-enabled RAM write; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < c_NBYTES; b++) begin
                if (wstrb[b]) begin
                    r_mem[r_widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rstate_t               r_rstate;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [MEMSIZE-1:0]    r_ridx;      // next word to fetch
    logic [7:0]            r_rlen;
    logic [7:0]            r_rcnt;      // beat currently presented
    logic [DATA_WIDTH-1:0] r_rdata;

    logic w_rfinal;
    logic w_rhs;
    logic w_re;

    assign w_rfinal = (r_rcnt == r_rlen);
    assign w_rhs    = (r_rstate == R_DATA) && rready;
    // Prefetch the next beat in the same cycle the current one is accepted,
    // so a continuously-ready master sees no bubbles. With no handshake the
    // RAM output register holds, keeping rdata stable during stalls.
    assign w_re     = (r_rstate == R_FETCH) || (w_rhs && !w_rfinal);

    // Non-blocking read of r_mem gives read-first behaviour on collisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_re) begin
            r_rdata <= r_mem[r_ridx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_rid    <= '0;
            r_ridx   <= '0;
            r_rlen   <= '0;
            r_rcnt   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (arvalid) begin
                        r_rid    <= arid;
                        r_ridx   <= araddr[LSB +: MEMSIZE];
                        r_rlen   <= arlen;
                        r_rcnt   <= '0;
                        r_rstate <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    r_ridx   <= r_ridx + 1'b1;
                    r_rstate <= R_DATA;
                end
                R_DATA: begin
                    if (rready) begin
                        if (w_rfinal) begin
                            r_rstate <= R_IDLE;
                        end else begin
                            r_rcnt <= r_rcnt + 8'd1;
                            r_ridx <= r_ridx + 1'b1;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign arready = (r_rstate == R_IDLE);
    assign rvalid  = (r_rstate == R_DATA);
    assign rlast   = (r_rstate == R_DATA) && w_rfinal;
    assign rid     = r_rid;
    assign rdata   = r_rdata;
    assign rresp   = c_OKAY;

endmodule
`default_nettype wire

// File: doc/ninjin_ddr_resp.md
NINJIN_DDR_RESP -- requirements
Module: ninjin_ddr_resp

Interface
REQ-001 The block SHALL take parameters: ID_WIDTH, default 1, AXI ID width; ADDR_WIDTH, default MEMSIZE+LSB, byte-address width; DATA_WIDTH, default BWIDTH (32), beat width; MEMSIZE, default from ninjin.svh, log2 of word depth; LSB, default 2, byte-offset bits.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-003 The write address ports SHALL be: awid in ID_WIDTH; awaddr in ADDR_WIDTH; awlen in 8 (beats-1); awsize in 3; awburst in 2; awvalid in 1; awready out 1.
REQ-004 The write data ports SHALL be: wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8; wlast in 1; wvalid in 1; wready out 1.
REQ-005 The write response ports SHALL be: bid out ID_WIDTH; bresp out 2; bvalid out 1; bready in 1.
REQ-006 The read address ports SHALL be: arid in ID_WIDTH; araddr in ADDR_WIDTH; arlen in 8; arsize in 3; arburst in 2; arvalid in 1; arready out 1.
REQ-007 The read data ports SHALL be: rid out ID_WIDTH; rdata out DATA_WIDTH; rresp out 2; rlast out 1; rvalid out 1; rready in 1.

Function
REQ-008 The block SHALL be the AXI4 memory-side responder for the ninjin m_axi_image master, backed by 2**MEMSIZE words of DATA_WIDTH bits.
REQ-009 Word index SHALL be addr[LSB +: MEMSIZE]; upper bits ignored; index increments by 1 per beat and wraps modulo 2**MEMSIZE.
REQ-010 awsize/arsize and awburst/arburst SHALL be ignored; every burst is treated as INCR of full-width beats.
REQ-011 Write FSM states SHALL be W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE, wready=1 only in W_DATA, bvalid=1 only in W_RESP.
REQ-012 On AW handshake: latch awid, word index, awlen; beat counter=0; go to W_DATA next cycle.
REQ-013 Each W handshake SHALL write bytes whose wstrb bit is 1, leave others unchanged, then advance index and counter.
REQ-014 Write burst SHALL end on beat awlen+1 regardless of wlast; go to W_RESP next cycle.
REQ-015 bresp SHALL be 2'b00 if wlast was 1 on exactly the final beat and 0 on all earlier beats, else 2'b10; bid = latched awid.
REQ-016 bvalid/bresp/bid SHALL hold until bready=1; on B handshake return to W_IDLE next cycle.
REQ-017 Read FSM states SHALL be R_IDLE, R_FETCH, R_DATA; arready=1 only in R_IDLE.
REQ-018 On AR handshake in cycle N: latch arid, index, arlen; R_FETCH in N+1 issues synchronous RAM read; rvalid=1 from N+2.
REQ-019 In R_DATA, rdata/rlast/rid/rresp SHALL stay stable while rvalid=1 and rready=0.
REQ-020 With rready held 1, beats SHALL issue one per cycle with no bubbles.
REQ-021 rlast SHALL be 1 only on beat arlen+1; rresp always 2'b00; after last handshake rvalid=0 and R_IDLE next cycle.
REQ-022 Read and write FSMs SHALL operate independently and concurrently.
REQ-023 Same-word same-cycle read/write SHALL return pre-write data (read-first); writes complete before B handshake are visible to later reads.

Reset
REQ-024 While rst=1 at a clk edge: both FSMs to IDLE; awready=1, arready=1 from next cycle; wready, bvalid, rvalid, rlast=0; bresp, rresp=2'b00; bid, rid, rdata=0.
REQ-025 Reset mid-burst SHALL abandon the burst with no response; memory contents SHALL NOT be cleared.

Verification
REQ-026 Single write awaddr=0x10, awlen=0, wdata=0xDEADBEEF, wstrb=4'hF, wlast=1 -> bvalid one cycle after W handshake, bresp=00; read araddr=0x10, arlen=0 -> rvalid 2 cycles after AR, rdata=0xDEADBEEF, rlast=1.
REQ-027 Write awlen=15 at 0x100, data=beat index 0..15; read back with rready toggling every cycle -> 16 beats 0..15 in order, data stable during stalls, rlast only on 16th.
REQ-028 Write 0xFFFFFFFF to 0x20, then 0x12345678 with wstrb=4'b0011 -> read 0x20 returns 0xFFFF5678.
REQ-029 awlen=3 with wlast=1 on beat 2 -> all 4 beats accepted, bresp=2'b10, next burst unaffected.
REQ-030 Write at word 2**MEMSIZE-1, awlen=1 -> second beat lands in word 0; concurrent read burst elsewhere completes correctly.
REQ-031 Assert rst after 3 of 8 read beats -> next cycle rvalid=0, arready=1; re-read returns original data.
